// File: rtl/rgb_pkg.sv
// ---------------------------------------------------------------------------
// rgb_pkg
// Shared types and constants for the RGB PWM duty decoder.
//   rgb_color_t    : packed {r, g, b} byte triple, r in the top byte
//   dec_state_t    : control FSM states (IDLE, SETTLE, MEASURE)
//   SYNC_STAGES    : depth of the per-line input synchronizer
//   DUTY_MAX       : largest duty value that fits the 8-bit result
//   saturate_duty  : clamps a high-cycle count to DUTY_MAX
// ---------------------------------------------------------------------------
package rgb_pkg;

   localparam int SYNC_STAGES = 2;
   localparam int DUTY_MAX    = 255;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_color_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_MEASURE = 2'd2
   } dec_state_t;

   // A line stuck high for a whole window counts one past DUTY_MAX; clamp it
   // so a constant-high input still reads as full brightness.
   function automatic logic [7:0] saturate_duty(input logic [31:0] count);
      if (count > 32'(DUTY_MAX)) begin
         saturate_duty = 8'(DUTY_MAX);
      end else begin
         saturate_duty = count[7:0];
      end
   endfunction

endpackage

// File: rtl/rgb_pwm_decoder_meter.sv
// ---------------------------------------------------------------------------
// pwm_channel_meter
// Measures the high time of one asynchronous PWM line over a window.
//   pwm_clk     : clock, rising edge
//   reset_n     : asynchronous active-low reset
//   pwm_in      : asynchronous PWM line
//   count_en    : high while the decoder is measuring
//   window_last : high on the final cycle of a measurement window
//   duty        : saturated count including the current cycle's sample;
//                 only meaningful when window_last is high
// ---------------------------------------------------------------------------
module pwm_channel_meter
   import rgb_pkg::*;
#(
   parameter int CNT_W = 9
) (
   input  logic       pwm_clk,
   input  logic       reset_n,
   input  logic       pwm_in,
   input  logic       count_en,
   input  logic       window_last,
   output logic [7:0] duty
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic [CNT_W-1:0]       count_q;
   logic [CNT_W-1:0]       count_d;
   logic                   sample;
   logic [CNT_W-1:0]       count_sum;

   // The synchronizer always runs so it is already settled when measurement
   // starts. The counter returns to zero outside MEASURE and after the last
   // cycle of each window, so the next window starts clean with no gap.
   always_comb begin
      sync_d    = {sync_q[SYNC_STAGES-2:0], pwm_in};
      sample    = sync_q[SYNC_STAGES-1];
      count_sum = count_q + CNT_W'(sample);
      count_d   = (count_en && !window_last) ? count_sum : '0;
      duty      = saturate_duty(32'(count_sum));
   end

   always_ff @(posedge pwm_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         count_q <= '0;
      end else begin
         sync_q  <= sync_d;
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// rgb_pwm_decoder
// Decodes the duty cycle of three PWM lines (R, G, B) into a 24-bit colour
// once per window of 2^WINDOW_LOG2 cycles, with a valid/ready output.
//   pwm_clk      : sole clock, rising edge
//   reset_n      : asynchronous active-low reset
//   enable       : high runs measurement, low returns to IDLE
//   pwm_in_r/g/b : asynchronous PWM lines
//   invert       : only with RGB_PWM_DECODER_INVERT_EN defined; sampled at
//                  window end, stores complemented duties when high
//   color        : [23:16]=R, [15:8]=G, [7:0]=B
//   color_valid  : a result is held and not yet accepted
//   color_ready  : consumer accepts when color_valid && color_ready
//   overrun      : sticky, a result was overwritten before acceptance
//   overrun_clr  : clears overrun (a simultaneous new overrun wins)
// Optional feature macro: RGB_PWM_DECODER_INVERT_EN
// ---------------------------------------------------------------------------
module rgb_pwm_decoder
   import rgb_pkg::*;
#(
   parameter int WINDOW_LOG2 = 8
) (
   input  logic        pwm_clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        pwm_in_r,
   input  logic        pwm_in_g,
   input  logic        pwm_in_b,
`ifdef RGB_PWM_DECODER_INVERT_EN
   input  logic        invert,
`endif
   output logic [23:0] color,
   output logic        color_valid,
   input  logic        color_ready,
   output logic        overrun,
   input  logic        overrun_clr
);

   localparam int CNT_W = WINDOW_LOG2 + 1;

   dec_state_t             state_q;
   dec_state_t             state_d;
   logic                   settle_q;
   logic                   settle_d;
   logic [WINDOW_LOG2-1:0] win_cnt_q;
   logic [WINDOW_LOG2-1:0] win_cnt_d;
   rgb_color_t             color_q;
   rgb_color_t             color_d;
   logic                   color_valid_q;
   logic                   color_valid_d;
   logic                   overrun_q;
   logic                   overrun_d;

   logic                   measure_active;
   logic                   window_last;
   logic                   window_done;
   logic                   accept;
   logic [7:0]             duty_r;
   logic [7:0]             duty_g;
   logic [7:0]             duty_b;
   rgb_color_t             new_color;

   // Dropping enable suppresses counting and the window-end load in that
   // same cycle, so a partial window can never produce a result.
   always_comb begin
      measure_active = (state_q == ST_MEASURE) && enable;
      window_last    = (win_cnt_q == '1);
      window_done    = measure_active && window_last;
      accept         = color_valid_q && color_ready;
   end

   pwm_channel_meter #(.CNT_W(CNT_W)) u_meter_r (
      .pwm_clk     (pwm_clk),
      .reset_n     (reset_n),
      .pwm_in      (pwm_in_r),
      .count_en    (measure_active),
      .window_last (window_last),
      .duty        (duty_r)
   );

   pwm_channel_meter #(.CNT_W(CNT_W)) u_meter_g (
      .pwm_clk     (pwm_clk),
      .reset_n     (reset_n),
      .pwm_in      (pwm_in_g),
      .count_en    (measure_active),
      .window_last (window_last),
      .duty        (duty_g)
   );

   pwm_channel_meter #(.CNT_W(CNT_W)) u_meter_b (
      .pwm_clk     (pwm_clk),
      .reset_n     (reset_n),
      .pwm_in      (pwm_in_b),
      .count_en    (measure_active),
      .window_last (window_last),
      .duty        (duty_b)
   );

   // Assemble the result that a completing window would store.
   always_comb begin
      new_color.r = duty_r;
      new_color.g = duty_g;
      new_color.b = duty_b;
`ifdef RGB_PWM_DECODER_INVERT_EN
      if (invert) begin
         new_color = rgb_color_t'(~new_color);
      end
`endif
   end

   // Control FSM. SETTLE spends two cycles so the synchronizers are flushed
   // with post-enable samples before counting; the window counter wraps
   // naturally so windows run back-to-back.
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      win_cnt_d = win_cnt_q;
      case (state_q)
         ST_IDLE: begin
            settle_d  = 1'b0;
            win_cnt_d = '0;
            if (enable) begin
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            win_cnt_d = '0;
            if (!enable) begin
               state_d  = ST_IDLE;
               settle_d = 1'b0;
            end else if (settle_q) begin
               state_d  = ST_MEASURE;
               settle_d = 1'b0;
            end else begin
               settle_d = 1'b1;
            end
         end
         ST_MEASURE: begin
            if (!enable) begin
               state_d   = ST_IDLE;
               win_cnt_d = '0;
            end else begin
               win_cnt_d = win_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            settle_d  = 1'b0;
            win_cnt_d = '0;
         end
      endcase
   end

   // Output handshake and overrun. A completing window always wins: it
   // reloads color and keeps color_valid high even when the old result is
   // being accepted in the same cycle, and only flags overrun when the old
   // result was not being taken.
   always_comb begin
      color_d       = color_q;
      color_valid_d = color_valid_q;
      overrun_d     = overrun_q;
      if (accept) begin
         color_valid_d = 1'b0;
      end
      if (overrun_clr) begin
         overrun_d = 1'b0;
      end
      if (window_done) begin
         color_d       = new_color;
         color_valid_d = 1'b1;
         if (color_valid_q && !color_ready) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge pwm_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         settle_q      <= 1'b0;
         win_cnt_q     <= '0;
         color_q       <= '0;
         color_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         settle_q      <= settle_d;
         win_cnt_q     <= win_cnt_d;
         color_q       <= color_d;
         color_valid_q <= color_valid_d;
         overrun_q     <= overrun_d;
      end
   end

   assign color       = color_q;
   assign color_valid = color_valid_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm_decoder
// Scoreboard bench for rgb_pwm_decoder. Expected colours are pushed into a
// queue before each run; a monitor pops and compares on every accepted
// result. Direct checks cover reset, latency, overrun and valid timing.
// Latency counting: enable is raised just after a rising edge; the first
// result is visible after the 259th following edge, i.e. in cycle 260 when
// the cycle in which enable first reads high is numbered 1.
// Optional feature macro: RGB_PWM_DECODER_INVERT_EN
// ---------------------------------------------------------------------------
module tb_rgb_pwm_decoder;

   logic        pwm_clk;
   logic        reset_n;
   logic        enable;
   logic        pwm_in_r;
   logic        pwm_in_g;
   logic        pwm_in_b;
`ifdef RGB_PWM_DECODER_INVERT_EN
   logic        invert;
`endif
   logic [23:0] color;
   logic        color_valid;
   logic        color_ready;
   logic        overrun;
   logic        overrun_clr;

   int          check_cnt = 0;
   int          pass_cnt  = 0;
   logic [23:0] exp_q[$];

   logic [7:0]  pwm_phase;
   logic [7:0]  duty_r;
   logic [7:0]  duty_g;
   logic [7:0]  duty_b;
   logic        use_level;
   logic        level_r;
   logic        level_g;
   logic        level_b;

   rgb_pwm_decoder dut (
      .pwm_clk     (pwm_clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .pwm_in_r    (pwm_in_r),
      .pwm_in_g    (pwm_in_g),
      .pwm_in_b    (pwm_in_b),
`ifdef RGB_PWM_DECODER_INVERT_EN
      .invert      (invert),
`endif
      .color       (color),
      .color_valid (color_valid),
      .color_ready (color_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   initial begin
      pwm_clk = 1'b0;
      forever #5 pwm_clk = ~pwm_clk;
   end

   // Free-running 8-bit PWM source, deliberately off the clock edge.
   initial begin
      pwm_phase = 8'd0;
      forever begin
         @(posedge pwm_clk);
         #2;
         pwm_phase = pwm_phase + 8'd1;
      end
   end

   assign pwm_in_r = use_level ? level_r : (pwm_phase < duty_r);
   assign pwm_in_g = use_level ? level_g : (pwm_phase < duty_g);
   assign pwm_in_b = use_level ? level_b : (pwm_phase < duty_b);

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      check_cnt++;
      if (actual === expected) begin
         pass_cnt++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic en, input logic rdy, input logic clr);
      enable      = en;
      color_ready = rdy;
      overrun_clr = clr;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge pwm_clk);
         #1;
      end
   endtask

   // Advances at least one cycle, then until color_valid is seen or the
   // budget runs out; n reports the number of edges taken.
   task automatic waitValidRise(input int max_cycles, output int n);
      n = 0;
      do begin
         tick(1);
         n++;
      end while (!color_valid && n < max_cycles);
   endtask

   // Monitor: every accepted result must match the head of the queue.
   initial begin
      logic [23:0] exp_color;
      forever begin
         @(negedge pwm_clk);
         if (reset_n && color_valid && color_ready) begin
            if (exp_q.size() == 0) begin
               check_cnt++;
               $display("[TB] FAIL unexpected_result: got 0x%06h, expected no result", color);
            end else begin
               exp_color = exp_q.pop_front();
               checkOutput("scoreboard_color", {8'h00, color}, {8'h00, exp_color});
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      reset_n     = 1'b0;
      use_level   = 1'b0;
      level_r     = 1'b0;
      level_g     = 1'b0;
      level_b     = 1'b0;
      duty_r      = 8'h00;
      duty_g      = 8'h00;
      duty_b      = 8'h00;
`ifdef RGB_PWM_DECODER_INVERT_EN
      invert      = 1'b0;
`endif
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Reset state
      tick(3);
      checkOutput("reset_color", {8'h00, color}, 32'h0);
      checkOutput("reset_valid", {31'd0, color_valid}, 32'd0);
      checkOutput("reset_overrun", {31'd0, overrun}, 32'd0);
      reset_n = 1'b1;
      tick(2);

      // Streaming PWM 0x40/0x80/0xFF with ready held high
      duty_r = 8'h40; duty_g = 8'h80; duty_b = 8'hFF;
      repeat (3) exp_q.push_back(24'h4080FF);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitValidRise(400, n);
      checkOutput("first_latency", n, 259);
      waitValidRise(400, n);
      checkOutput("window_period_1", n, 256);
      waitValidRise(400, n);
      checkOutput("window_period_2", n, 256);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(5);

      // Stuck-high red saturates; a window completing during acceptance
      // reloads with valid kept high and no overrun
      use_level = 1'b1; level_r = 1'b1; level_g = 1'b0; level_b = 1'b0;
      tick(4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitValidRise(400, n);
      checkOutput("stuck_latency", n, 259);
      checkOutput("stuck_color", {8'h00, color}, 32'h00FF0000);
      tick(255);
      exp_q.push_back(24'hFF0000);
      exp_q.push_back(24'hFF0000);
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(1);
      checkOutput("coincide_valid", {31'd0, color_valid}, 32'd1);
      checkOutput("coincide_overrun", {31'd0, overrun}, 32'd0);
      tick(1);
      checkOutput("coincide_drop_valid", {31'd0, color_valid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(5);

      // Overrun: first window FF00FF, then levels change right after it so
      // the second window sees 2 old + 254 new samples -> 02FEFF
      level_r = 1'b1; level_g = 1'b0; level_b = 1'b1;
      tick(4);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitValidRise(400, n);
      checkOutput("ovr_first_color", {8'h00, color}, 32'h00FF00FF);
      checkOutput("ovr_first_flag", {31'd0, overrun}, 32'd0);
      level_r = 1'b0; level_g = 1'b1; level_b = 1'b1;
      tick(256);
      checkOutput("ovr_valid_held", {31'd0, color_valid}, 32'd1);
      checkOutput("ovr_flag_set", {31'd0, overrun}, 32'd1);
      checkOutput("ovr_second_color", {8'h00, color}, 32'h0002FEFF);
      exp_q.push_back(24'h02FEFF);
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("ovr_accepted", {31'd0, color_valid}, 32'd0);
      tick(1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("ovr_cleared", {31'd0, overrun}, 32'd0);
      tick(5);

      // Abort 100 cycles into a window, resume 10 cycles later
      use_level = 1'b0;
      duty_r = 8'h10; duty_g = 8'h20; duty_b = 8'h30;
      applyStimulus(1'b1, 1'b1, 1'b0);
      tick(103);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(10);
      checkOutput("abort_no_result", {31'd0, color_valid}, 32'd0);
      exp_q.push_back(24'h102030);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitValidRise(400, n);
      checkOutput("reenable_latency", n, 259);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(5);

      // Asynchronous reset mid-window with a pending result and overrun
      duty_r = 8'h40; duty_g = 8'h80; duty_b = 8'hFF;
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitValidRise(400, n);
      tick(256);
      checkOutput("pre_reset_valid", {31'd0, color_valid}, 32'd1);
      checkOutput("pre_reset_overrun", {31'd0, overrun}, 32'd1);
      tick(50);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_reset_color", {8'h00, color}, 32'h0);
      checkOutput("async_reset_valid", {31'd0, color_valid}, 32'd0);
      checkOutput("async_reset_overrun", {31'd0, overrun}, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick(2);
      reset_n = 1'b1;
      tick(3);

`ifdef RGB_PWM_DECODER_INVERT_EN
      // Inverted storage: 00/10/FF -> FF/EF/00
      invert = 1'b1;
      duty_r = 8'h00; duty_g = 8'h10; duty_b = 8'hFF;
      exp_q.push_back(24'hFFEF00);
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitValidRise(400, n);
      checkOutput("invert_latency", n, 259);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick(5);
`endif

      checkOutput("scoreboard_drained", exp_q.size(), 0);
      tick(2);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
